// File: rtl/modulo_gerenciador_rolhas_param.sv
// rtl/modulo_gerenciador_rolhas_param.sv - cork manager: buffer loading, refill transfers into main reservoir, sealing consumption
// Optional build macro: ROLHAS_EDGE_DET_EN (add_req/consume treated as levels, event = registered rising edge)
module modulo_gerenciador_rolhas_param #(
  parameter int W        = 7,
  parameter int MAX_BUF  = 99,
  parameter int CAP_MAIN = 20,
  parameter int MIN_MAIN = 5,
  parameter int LOTE     = 15
) (
  input  logic         clk,
  input  logic         Nclr,
  input  logic         enable,
  input  logic         add_req,
  input  logic [W-1:0] add_qty,
  input  logic         consume,
  output logic [W-1:0] main_cnt,
  output logic [W-1:0] buf_cnt,
  output logic         transfer_busy,
  output logic         ro,
  output logic         low_buf,
  output logic         add_ack,
  output logic         add_err,
  output logic         cons_err
);

  typedef enum logic {IDLE, TRANSFER} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   lot_cnt;
  logic           add_ev;
  logic           cons_ev;
  logic [W:0]     add_sum;
  logic           add_ok;
  logic           cons_acc;
  logic [W-1:0]   main_after_cons;
  logic           move;
  logic [W-1:0]   main_nxt;
  logic [W-1:0]   buf_nxt;
  logic [W-1:0]   lot_nxt;

`ifdef ROLHAS_EDGE_DET_EN
  logic add_hist;
  logic cons_hist;

  // Register the rising edge of each level input so a long hold yields one event
  always_ff @(posedge clk or negedge Nclr) begin
    if (!Nclr) begin
      add_hist  <= 1'b0;
      cons_hist <= 1'b0;
      add_ev    <= 1'b0;
      cons_ev   <= 1'b0;
    end else begin
      add_hist  <= add_req;
      cons_hist <= consume;
      add_ev    <= add_req & ~add_hist;
      cons_ev   <= consume & ~cons_hist;
    end
  end
`else
  assign add_ev  = add_req;
  assign cons_ev = consume;
`endif

  // Event arbitration: overflow check on pre-edge buffer, consume ignored when main is empty
  always_comb begin
    add_sum         = {1'b0, buf_cnt} + {1'b0, add_qty};
    add_ok          = add_ev && (add_sum <= (W+1)'(MAX_BUF));
    cons_acc        = cons_ev && (main_cnt != '0);
    main_after_cons = main_cnt - W'(cons_acc);
    move            = (state == TRANSFER) && enable && (buf_cnt != '0) &&
                      (main_after_cons < W'(CAP_MAIN));
    main_nxt        = main_after_cons + W'(move);
    buf_nxt         = buf_cnt - W'(move) + (add_ok ? add_qty : '0);
    lot_nxt         = lot_cnt + W'(move);
  end

  // State register
  always_ff @(posedge clk or negedge Nclr) begin
    if (!Nclr) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: start a refill when main runs low, stop on lot/empty/full/disable
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable && (main_cnt < W'(MIN_MAIN)) && (buf_cnt != '0))
          state_nxt = TRANSFER;
      end
      TRANSFER: begin
        if (!enable || (lot_nxt == W'(LOTE)) || (buf_nxt == '0) ||
            (main_nxt == W'(CAP_MAIN)))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    transfer_busy = (state == TRANSFER);
  end

  // Counters; the lot counter sits at zero in IDLE so it is clear on entry to TRANSFER
  always_ff @(posedge clk or negedge Nclr) begin
    if (!Nclr) begin
      main_cnt <= '0;
      buf_cnt  <= '0;
      lot_cnt  <= '0;
    end else begin
      main_cnt <= main_nxt;
      buf_cnt  <= buf_nxt;
      lot_cnt  <= (state == TRANSFER) ? lot_nxt : '0;
    end
  end

  // One-cycle status pulses
  always_ff @(posedge clk or negedge Nclr) begin
    if (!Nclr) begin
      add_ack  <= 1'b0;
      add_err  <= 1'b0;
      cons_err <= 1'b0;
    end else begin
      add_ack  <= add_ok;
      add_err  <= add_ev && !add_ok;
      cons_err <= cons_ev && (main_cnt == '0);
    end
  end

  assign ro      = (main_cnt == '0);
  assign low_buf = (buf_cnt < W'(LOTE));

endmodule

// File: tb/tb_modulo_gerenciador_rolhas_param.sv
// tb/tb_modulo_gerenciador_rolhas_param.sv - self-checking bench for modulo_gerenciador_rolhas_param
module tb_modulo_gerenciador_rolhas_param;

  logic       clk = 1'b0;
  logic       Nclr = 1'b0;
  logic       enable = 1'b0;
  logic       add_req = 1'b0;
  logic [6:0] add_qty = 7'd0;
  logic       consume = 1'b0;
  logic [6:0] main_cnt;
  logic [6:0] buf_cnt;
  logic       transfer_busy;
  logic       ro;
  logic       low_buf;
  logic       add_ack;
  logic       add_err;
  logic       cons_err;

  int errors = 0;
  int checks = 0;

  int m_main, m_buf, m_lot;
  bit m_xfer, m_ack, m_aerr, m_cerr;

  modulo_gerenciador_rolhas_param dut (
    .clk(clk), .Nclr(Nclr), .enable(enable), .add_req(add_req), .add_qty(add_qty),
    .consume(consume), .main_cnt(main_cnt), .buf_cnt(buf_cnt),
    .transfer_busy(transfer_busy), .ro(ro), .low_buf(low_buf),
    .add_ack(add_ack), .add_err(add_err), .cons_err(cons_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_main = 0; m_buf = 0; m_lot = 0;
    m_xfer = 0; m_ack = 0; m_aerr = 0; m_cerr = 0;
  endtask

  // Drive one cycle of inputs, advance the reference model by the same cycle, sample 1 ns after the edge
  task automatic tick(input bit en, input bit add, input int qty, input bit cons);
    int  old_main, old_buf, cacc, mv;
    bit  a_ok;
    enable = en; add_req = add; add_qty = 7'(qty); consume = cons;
    old_main = m_main;
    old_buf  = m_buf;
    a_ok   = add && (old_buf + qty <= 99);
    cacc   = (cons && old_main > 0) ? 1 : 0;
    mv     = (m_xfer && en && old_buf > 0 && (old_main - cacc) < 20) ? 1 : 0;
    m_ack  = a_ok;
    m_aerr = add && !a_ok;
    m_cerr = cons && (old_main == 0);
    m_main = old_main - cacc + mv;
    m_buf  = old_buf - mv + (a_ok ? qty : 0);
    if (!m_xfer) begin
      m_lot = 0;
      if (en && old_main < 5 && old_buf > 0) m_xfer = 1;
    end else begin
      m_lot = m_lot + mv;
      if (!en || m_lot == 15 || m_buf == 0 || m_main == 20) begin
        m_xfer = 0;
        m_lot  = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    enable = 0; add_req = 0; add_qty = 0; consume = 0;
    Nclr = 0;
    @(posedge clk);
    #1;
    Nclr = 1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({main_cnt, buf_cnt, transfer_busy, ro, low_buf, add_ack, add_err, cons_err} !==
        {7'd0, 7'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: main=%0d buf=%0d busy=%b ro=%b low=%b ack=%b aerr=%b cerr=%b, required 0 0 0 1 1 0 0 0",
               main_cnt, buf_cnt, transfer_busy, ro, low_buf, add_ack, add_err, cons_err);
    end
  endtask

  task automatic test_add();
    tick(0, 1, 50, 0);
    checks++;
    if (buf_cnt !== 7'd50 || add_ack !== 1'b1 || add_err !== 1'b0) begin
      errors++;
      $display("FAIL add_50: buf=%0d ack=%b err=%b, required buf=50 ack=1 err=0", buf_cnt, add_ack, add_err);
    end
    tick(0, 0, 0, 0);
    checks++;
    if (add_ack !== 1'b0 || buf_cnt !== 7'd50) begin
      errors++;
      $display("FAIL add_ack_one_cycle: ack=%b buf=%0d, required ack=0 buf=50", add_ack, buf_cnt);
    end
    tick(0, 1, 60, 0);
    checks++;
    if (buf_cnt !== 7'd50 || add_err !== 1'b1 || add_ack !== 1'b0) begin
      errors++;
      $display("FAIL add_overflow: buf=%0d ack=%b err=%b, required buf=50 ack=0 err=1", buf_cnt, add_ack, add_err);
    end
    tick(0, 1, 0, 0);
    checks++;
    if (buf_cnt !== 7'd50 || add_ack !== 1'b1 || add_err !== 1'b0) begin
      errors++;
      $display("FAIL add_zero: buf=%0d ack=%b err=%b, required buf=50 ack=1 err=0", buf_cnt, add_ack, add_err);
    end
  endtask

  task automatic test_transfer();
    int busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1, 0, 0, 0);
      if (transfer_busy) busy_cycles++;
    end
    checks++;
    if (busy_cycles != 15) begin
      errors++;
      $display("FAIL transfer_busy_len: got %0d cycles, required 15", busy_cycles);
    end
    checks++;
    if (main_cnt !== 7'd15 || buf_cnt !== 7'd35 || transfer_busy !== 1'b0 || ro !== 1'b0 || low_buf !== 1'b0) begin
      errors++;
      $display("FAIL transfer_final: main=%0d buf=%0d busy=%b ro=%b low=%b, required 15 35 0 0 0",
               main_cnt, buf_cnt, transfer_busy, ro, low_buf);
    end
  endtask

  task automatic test_small_lot();
    int busy_cycles = 0;
    apply_reset();
    tick(0, 1, 3, 0);
    for (int i = 0; i < 12; i++) begin
      tick(1, 0, 0, 0);
      if (transfer_busy) busy_cycles++;
    end
    checks++;
    if (busy_cycles != 3 || main_cnt !== 7'd3 || buf_cnt !== 7'd0 || low_buf !== 1'b1 || transfer_busy !== 1'b0) begin
      errors++;
      $display("FAIL small_lot: busy=%0d main=%0d buf=%0d low=%b busy_now=%b, required 3 3 0 1 0",
               busy_cycles, main_cnt, buf_cnt, low_buf, transfer_busy);
    end
  endtask

  task automatic test_consume();
    apply_reset();
    tick(0, 0, 0, 1);
    checks++;
    if (cons_err !== 1'b1 || main_cnt !== 7'd0) begin
      errors++;
      $display("FAIL consume_empty: cerr=%b main=%0d, required cerr=1 main=0", cons_err, main_cnt);
    end
    tick(0, 1, 50, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    checks++;
    if (transfer_busy !== 1'b1 || main_cnt !== 7'd1 || buf_cnt !== 7'd49 || cons_err !== 1'b0) begin
      errors++;
      $display("FAIL consume_setup: busy=%b main=%0d buf=%0d cerr=%b, required 1 1 49 0",
               transfer_busy, main_cnt, buf_cnt, cons_err);
    end
    tick(1, 0, 0, 1);
    checks++;
    if (main_cnt !== 7'd1 || buf_cnt !== 7'd48 || cons_err !== 1'b0) begin
      errors++;
      $display("FAIL consume_on_move: main=%0d buf=%0d cerr=%b, required 1 48 0", main_cnt, buf_cnt, cons_err);
    end
    tick(1, 1, 10, 0);
    checks++;
    if (main_cnt !== 7'd2 || buf_cnt !== 7'd57 || add_ack !== 1'b1) begin
      errors++;
      $display("FAIL add_on_move: main=%0d buf=%0d ack=%b, required 2 57 1", main_cnt, buf_cnt, add_ack);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int k = 1; k <= 6; k++) begin
      tick(0, 1, 20, 0);
      checks++;
      if (buf_cnt !== 7'((k <= 4) ? 20 * k : 80) || add_err !== (k > 4) || add_ack !== (k <= 4)) begin
        errors++;
        $display("FAIL hold_add_%0d: buf=%0d ack=%b err=%b, required buf=%0d ack=%b err=%b",
                 k, buf_cnt, add_ack, add_err, (k <= 4) ? 20 * k : 80, k <= 4, k > 4);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    tick(0, 1, 47, 0);
    for (int i = 0; i < 8; i++) tick(1, 0, 0, 0);
    checks++;
    if (main_cnt !== 7'd7 || buf_cnt !== 7'd40 || transfer_busy !== 1'b1) begin
      errors++;
      $display("FAIL async_setup: main=%0d buf=%0d busy=%b, required 7 40 1", main_cnt, buf_cnt, transfer_busy);
    end
    #2;
    Nclr = 0;
    #1;
    checks++;
    if (main_cnt !== 7'd0 || buf_cnt !== 7'd0 || ro !== 1'b1 || transfer_busy !== 1'b0 || low_buf !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: main=%0d buf=%0d ro=%b busy=%b low=%b, required 0 0 1 0 1",
               main_cnt, buf_cnt, ro, transfer_busy, low_buf);
    end
    #2;
    Nclr = 1;
    model_reset();
    tick(0, 1, 5, 0);
    checks++;
    if (buf_cnt !== 7'd5 || add_ack !== 1'b1 || transfer_busy !== 1'b0) begin
      errors++;
      $display("FAIL resume_after_reset: buf=%0d ack=%b busy=%b, required 5 1 0", buf_cnt, add_ack, transfer_busy);
    end
  endtask

  task automatic test_random();
    logic [20:0] exp_v;
    logic [20:0] got_v;
    apply_reset();
    for (int i = 0; i < 500; i++) begin
      tick(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 2),
           int'($urandom_range(0, 40)), ($urandom_range(0, 9) < 4));
      exp_v = {7'(m_main), 7'(m_buf), m_xfer, (m_main == 0), (m_buf < 15), m_ack, m_aerr, m_cerr};
      got_v = {main_cnt, buf_cnt, transfer_busy, ro, low_buf, add_ack, add_err, cons_err};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL random_cycle_%0d: main=%0d buf=%0d busy=%b ro=%b low=%b ack=%b aerr=%b cerr=%b, required main=%0d buf=%0d busy=%b ro=%b low=%b ack=%b aerr=%b cerr=%b",
                 i, main_cnt, buf_cnt, transfer_busy, ro, low_buf, add_ack, add_err, cons_err,
                 m_main, m_buf, m_xfer, m_main == 0, m_buf < 15, m_ack, m_aerr, m_cerr);
      end
    end
  endtask

  initial begin
    model_reset();
    #3;
    test_reset();
    test_add();
    test_transfer();
    test_small_lot();
    test_consume();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
